// File: rtl/prm_lgc_pkg.sv
// Shared types and sizing for the programmable PRM edge-mask engine.
// Cube storage is organised as ROWS rows of CUBE_PAR cubes per edge.
package prm_lgc_pkg;

    localparam int IN_W           = 15;
    localparam int NUM_EDGES      = 8;
    localparam int CUBES_PER_EDGE = 128;
    localparam int CUBE_PAR       = 4;
    localparam int ROWS           = CUBES_PER_EDGE / CUBE_PAR;
    localparam int EDGE_W         = $clog2(NUM_EDGES);
    localparam int IDX_W          = $clog2(CUBES_PER_EDGE);
    localparam int ROW_W          = $clog2(ROWS);
    localparam int PAR_W          = $clog2(CUBE_PAR);

    typedef struct packed {
        logic [IN_W-1:0] care;
        logic [IN_W-1:0] val;
        logic            vld;
    } cube_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

endpackage

// File: rtl/prm_cube_row_match.sv
// Combinational match of one query against one row of CUBE_PAR cubes.
// Output is the OR of all valid cube matches in the row.
module prm_cube_row_match
    import prm_lgc_pkg::*;
(
    input  logic [IN_W-1:0]          q,
    input  cube_t [CUBE_PAR-1:0]     cubes,
    output logic                     hit
);

    always_comb begin
        hit = 1'b0;
        for (int c = 0; c < CUBE_PAR; c++) begin
            if (cubes[c].vld &&
                ((q & cubes[c].care) == (cubes[c].val & cubes[c].care))) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Programmable per-edge sum-of-products collision mask evaluator.
// Scans one cube row per cycle for all edges, with early exit when all edges hit.
module prm_edge_mask_engine
    import prm_lgc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic                 cfg_clr,
    input  logic [EDGE_W-1:0]    cfg_edge,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [IN_W-1:0]      cfg_care,
    input  logic [IN_W-1:0]      cfg_val,
    input  logic                 cfg_vld,
    output logic                 cfg_ready,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic [IN_W-1:0]      q_data,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [NUM_EDGES-1:0] r_mask,
    output logic [ROW_W:0]       r_rows
);

    state_t               state;
    logic [IN_W-1:0]      q_reg;
    logic [NUM_EDGES-1:0] hit;
    logic [NUM_EDGES-1:0] new_hits;
    logic [NUM_EDGES-1:0] acc;
    logic [ROW_W-1:0]     row;

    logic [IN_W-1:0]     care_q [NUM_EDGES][ROWS][CUBE_PAR];
    logic [IN_W-1:0]     val_q  [NUM_EDGES][ROWS][CUBE_PAR];
    logic [CUBE_PAR-1:0] vld_q  [NUM_EDGES][ROWS];

    logic             idle;
    logic             wr_en;
    logic             clr_en;
    logic [ROW_W-1:0] wr_row;
    logic [PAR_W-1:0] wr_col;

    assign idle      = (state == IDLE);
    assign q_ready   = idle;
    assign cfg_ready = idle;
    assign clr_en    = idle && cfg_clr;
    assign wr_en     = idle && cfg_we && !cfg_clr;
    assign wr_row    = cfg_idx[IDX_W-1:PAR_W];
    assign wr_col    = cfg_idx[PAR_W-1:0];
    assign acc       = hit | new_hits;

    // Cube literals are not reset; only the valid bits gate matching.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            care_q[cfg_edge][wr_row][wr_col] <= cfg_care;
            val_q[cfg_edge][wr_row][wr_col]  <= cfg_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_EDGES; e++)
                for (int r = 0; r < ROWS; r++)
                    vld_q[e][r] <= '0;
        end else if (clr_en) begin
            for (int e = 0; e < NUM_EDGES; e++)
                for (int r = 0; r < ROWS; r++)
                    vld_q[e][r] <= '0;
        end else if (wr_en) begin
            vld_q[cfg_edge][wr_row][wr_col] <= cfg_vld;
        end
    end

    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
        cube_t [CUBE_PAR-1:0] row_cubes;

        always_comb begin
            for (int c = 0; c < CUBE_PAR; c++) begin
                row_cubes[c].care = care_q[e][row][c];
                row_cubes[c].val  = val_q[e][row][c];
                row_cubes[c].vld  = vld_q[e][row][c];
            end
        end

        prm_cube_row_match u_match (
            .q     (q_reg),
            .cubes (row_cubes),
            .hit   (new_hits[e])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q_reg   <= '0;
            hit     <= '0;
            row     <= '0;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_rows  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (q_valid) begin
                        state <= EVAL;
                        q_reg <= q_data;
                        hit   <= '0;
                        row   <= '0;
                    end
                end
                EVAL: begin
                    hit <= acc;
                    if (row == ROW_W'(ROWS - 1) || &acc)
                        state <= DONE;
                    else
                        row <= row + 1'b1;
                end
                DONE: begin
                    // First DONE cycle publishes; result then holds until taken.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_mask  <= hit;
                        r_rows  <= {1'b0, row} + (ROW_W + 1)'(1);
                    end else if (r_ready) begin
                        r_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
